// File: rtl/stopwatch_bcd.sv
// ============================================================================
// stopwatch_bcd
// ----------------------------------------------------------------------------
// Eight-digit BCD stopwatch (HH:MM:SS.cc). A prescaler divides clk100MHZ down
// to a centisecond tick. Each tick advances a BCD digit chain that runs from
// 00:00:00.00 to 99:59:59.99 and then wraps. The digit outputs feed an
// eight-digit dynamic-scan display stage directly.
//
// Optional feature macro: STOPWATCH_LAP_EN
//   When it is defined, a lap pulse freezes the displayed digits while the
//   live count keeps running. When it is undefined, lap is ignored,
//   lap_active is tied low and no display register is built.
//
// Parameters
//   TICK_DIV    clock cycles per centisecond tick (>= 2)
//
// Ports
//   clk100MHZ   in   system clock, rising edge
//   rst         in   asynchronous active-high reset
//   start_stop  in   single-cycle pulse, toggles run/stop
//   clear       in   single-cycle pulse, zeroes the count when not running
//   lap         in   single-cycle pulse, toggles lap freeze
//   power_led   out  display enable, 1 whenever not in reset
//   dig0..dig7  out  [3:0] BCD digit, [7:4] always 0
//                    dig0/1 = cs units/tens, dig2/3 = s, dig4/5 = min,
//                    dig6/7 = hours
//   running     out  1 while counting
//   lap_active  out  1 while the displayed digits are frozen
//   ovf         out  sticky flag, set on the wrap to 00:00:00.00
// ============================================================================
module stopwatch_bcd #(
    parameter int unsigned TICK_DIV = 1000000
) (
    input  logic       clk100MHZ,
    input  logic       rst,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       lap,
    output logic       power_led,
    output logic [7:0] dig0,
    output logic [7:0] dig1,
    output logic [7:0] dig2,
    output logic [7:0] dig3,
    output logic [7:0] dig4,
    output logic [7:0] dig5,
    output logic [7:0] dig6,
    output logic [7:0] dig7,
    output logic       running,
    output logic       lap_active,
    output logic       ovf
);

    localparam int unsigned    PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0]  TICK_LAST = PW'(TICK_DIV - 1);

    // Wrap value of each digit, index 0 = centisecond units.
    localparam logic [7:0][3:0] DIG_MAX = {4'd9, 4'd9, 4'd5, 4'd9,
                                           4'd5, 4'd9, 4'd9, 4'd9};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STOP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [7:0][3:0] cnt_q,   cnt_d;
    logic            ovf_q,   ovf_d;
    logic            power_led_q;

    logic            clear_ok;   // clear is honoured only outside RUN
    logic            tick;
    logic            carry;
    logic [7:0][3:0] disp;

    // ------------------------------------------------------------------------
    // Next-state, prescaler and BCD chain
    // ------------------------------------------------------------------------
    // NOTE: every signal written in always_comb gets a default before any
    // branch. A path that leaves it unassigned would infer a latch.
    always_comb begin
        clear_ok = clear && (state_q != S_RUN);
        tick     = (state_q == S_RUN) && (presc_q == TICK_LAST);

        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start_stop && !clear) state_d = S_RUN;
            S_RUN:   if (start_stop)           state_d = S_STOP;
            S_STOP:  if (clear)                state_d = S_IDLE;
                     else if (start_stop)      state_d = S_RUN;
            default:                           state_d = S_IDLE;
        endcase

        // The prescaler is held outside RUN, so a pause keeps the partial
        // centisecond. Going back to IDLE discards it.
        presc_d = presc_q;
        if (clear_ok)
            presc_d = '0;
        else if (state_q == S_RUN)
            presc_d = tick ? '0 : presc_q + PW'(1);

        // Ripple the carry up the digit chain. A carry that leaves the top
        // digit means the wrap from 99:59:59.99.
        cnt_d = cnt_q;
        carry = 1'b0;
        if (clear_ok) begin
            cnt_d = '0;
        end else if (tick) begin
            carry = 1'b1;
            for (int i = 0; i < 8; i++) begin
                if (carry) begin
                    if (cnt_q[i] == DIG_MAX[i]) begin
                        cnt_d[i] = 4'd0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 4'd1;
                        carry    = 1'b0;
                    end
                end
            end
        end

        ovf_d = ovf_q;
        if (clear_ok)
            ovf_d = 1'b0;
        else if (carry)
            ovf_d = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk100MHZ or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            presc_q     <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            power_led_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            power_led_q <= 1'b1;
        end
    end

`ifdef STOPWATCH_LAP_EN
    // ------------------------------------------------------------------------
    // Lap freeze: capture the count shown at the lap edge, then display the
    // captured value until a second lap pulse or an honoured clear.
    // ------------------------------------------------------------------------
    logic            lap_q, lap_d;
    logic [7:0][3:0] frz_q, frz_d;

    always_comb begin
        lap_d = lap_q;
        frz_d = frz_q;
        if (clear_ok)
            lap_d = 1'b0;
        if (lap) begin
            if (lap_q) begin
                lap_d = 1'b0;
            end else if (state_q == S_RUN) begin
                lap_d = 1'b1;
                frz_d = cnt_q;
            end
        end
    end

    // NOTE: the display register is small and is reset with everything else,
    // so rst gives fully defined outputs even in the middle of a lap.
    always_ff @(posedge clk100MHZ or posedge rst) begin
        if (rst) begin
            lap_q <= 1'b0;
            frz_q <= '0;
        end else begin
            lap_q <= lap_d;
            frz_q <= frz_d;
        end
    end

    assign disp       = lap_q ? frz_q : cnt_q;
    assign lap_active = lap_q;
`else
    logic unused_lap;
    assign unused_lap = lap;
    assign disp       = cnt_q;
    assign lap_active = 1'b0;
`endif

    // Outputs are decoded from flops only. No input reaches them
    // combinationally.
    assign power_led = power_led_q;
    assign running   = (state_q == S_RUN);
    assign ovf       = ovf_q;

    assign dig0 = {4'b0000, disp[0]};
    assign dig1 = {4'b0000, disp[1]};
    assign dig2 = {4'b0000, disp[2]};
    assign dig3 = {4'b0000, disp[3]};
    assign dig4 = {4'b0000, disp[4]};
    assign dig5 = {4'b0000, disp[5]};
    assign dig6 = {4'b0000, disp[6]};
    assign dig7 = {4'b0000, disp[7]};

endmodule

// File: tb/tb_stopwatch_bcd.sv
// ============================================================================
// tb_stopwatch_bcd
// ----------------------------------------------------------------------------
// Directed and random stimulus for stopwatch_bcd with TICK_DIV = 4. The
// reference model keeps elapsed time as a plain centisecond count and derives
// the displayed digits from it arithmetically.
// ============================================================================
module tb_stopwatch_bcd;

    localparam int TD    = 4;
    localparam int LIMIT = 36000000;   // centiseconds in 100 hours

    logic       clk100MHZ;
    logic       rst;
    logic       start_stop;
    logic       clear;
    logic       lap;
    logic       power_led;
    logic [7:0] dig [8];
    logic       running;
    logic       lap_active;
    logic       ovf;

    stopwatch_bcd #(.TICK_DIV(TD)) dut (
        .clk100MHZ  (clk100MHZ),
        .rst        (rst),
        .start_stop (start_stop),
        .clear      (clear),
        .lap        (lap),
        .power_led  (power_led),
        .dig0       (dig[0]),
        .dig1       (dig[1]),
        .dig2       (dig[2]),
        .dig3       (dig[3]),
        .dig4       (dig[4]),
        .dig5       (dig[5]),
        .dig6       (dig[6]),
        .dig7       (dig[7]),
        .running    (running),
        .lap_active (lap_active),
        .ovf        (ovf)
    );

    initial clk100MHZ = 1'b0;
    always #5 clk100MHZ = ~clk100MHZ;

    // ---------------- reference model ----------------
    typedef enum {M_IDLE, M_RUN, M_STOP} mstate_t;

    mstate_t m_state;
    int      m_total;
    int      m_presc;
    bit      m_ovf;
    bit      m_lap;
    int      m_frozen;
    bit      m_power;

    int n_vec;
    int n_cmp;
    int n_bad;

    task automatic model_reset(input bit power);
        m_state  = M_IDLE;
        m_total  = 0;
        m_presc  = 0;
        m_ovf    = 0;
        m_lap    = 0;
        m_frozen = 0;
        m_power  = power;
    endtask

    // Effect of one clock edge with the given pulses present before it.
    task automatic model_edge(input bit ss, input bit cl, input bit lp);
        bit run_now;
        bit honoured;
        run_now  = (m_state == M_RUN);
        honoured = cl && !run_now;
`ifdef STOPWATCH_LAP_EN
        if (lp) begin
            if (m_lap) m_lap = 0;
            else if (run_now) begin
                m_lap    = 1;
                m_frozen = m_total;
            end
        end
        if (honoured) m_lap = 0;
`else
        if (lp) m_lap = 0;
`endif
        if (honoured) begin
            m_state = M_IDLE;
            m_total = 0;
            m_presc = 0;
            m_ovf   = 0;
        end else if (run_now) begin
            if (m_presc == TD - 1) begin
                m_presc = 0;
                m_total = m_total + 1;
                if (m_total == LIMIT) begin
                    m_total = 0;
                    m_ovf   = 1;
                end
            end else begin
                m_presc = m_presc + 1;
            end
            if (ss) m_state = M_STOP;
        end else if (ss) begin
            m_state = M_RUN;
        end
        m_power = 1;
    endtask

    function automatic logic [7:0] exp_dig(input int t, input int i);
        int cs, s, mi, h, v;
        cs = t % 100;
        s  = (t / 100) % 60;
        mi = (t / 6000) % 60;
        h  = t / 360000;
        case (i)
            0:       v = cs % 10;
            1:       v = cs / 10;
            2:       v = s % 10;
            3:       v = s / 10;
            4:       v = mi % 10;
            5:       v = mi / 10;
            6:       v = h % 10;
            default: v = h / 10;
        endcase
        return 8'(v);
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        int shown;
        shown = m_lap ? m_frozen : m_total;
        for (int i = 0; i < 8; i++)
            check($sformatf("dig%0d", i), {24'd0, dig[i]}, {24'd0, exp_dig(shown, i)});
        check("running",    {31'd0, running},    {31'd0, m_state == M_RUN});
        check("lap_active", {31'd0, lap_active}, {31'd0, m_lap});
        check("ovf",        {31'd0, ovf},        {31'd0, m_ovf});
        check("power_led",  {31'd0, power_led},  {31'd0, m_power});
    endtask

    // One clock: drive pulses, take the edge, advance the model, compare at
    // 1 time unit past the edge.
    task automatic cycle(input bit ss, input bit cl, input bit lp);
        start_stop = ss;
        clear      = cl;
        lap        = lp;
        @(posedge clk100MHZ);
        model_edge(ss, cl, lp);
        #1;
        n_vec++;
        check_all();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int guard;
        n_vec = 0;
        n_cmp = 0;
        n_bad = 0;
        start_stop = 0;
        clear      = 0;
        lap        = 0;

        // Reset asserted from time zero: outputs must already be at reset
        // values before any clock edge.
        rst = 1;
        model_reset(0);
        #3;
        check_all();
        @(posedge clk100MHZ);
        #1;
        check_all();
        rst = 0;
        cycle(0, 0, 0);
        check("pwr_after_rst", {31'd0, power_led}, 32'd1);

        // Start, then 40 cycles: 10 ticks -> 00:00:00.10.
        cycle(1, 0, 0);
        check("start_running", {31'd0, running}, 32'd1);
        idle_cycles(40);
        check("t40_dig0", {24'd0, dig[0]}, 32'd0);
        check("t40_dig1", {24'd0, dig[1]}, 32'd1);
        check("t40_run",  {31'd0, running}, 32'd1);

        // Run up to 59.99 s, then take one more tick.
        guard = 0;
        while (!(m_total == 5999 && m_presc == TD - 1) && guard < 30000) begin
            cycle(0, 0, 0);
            guard++;
        end
        if (guard >= 30000) check("timeout_5999", 32'd0, 32'd1);
        check("s59_dig3", {24'd0, dig[3]}, 32'd5);
        check("s59_dig2", {24'd0, dig[2]}, 32'd9);
        check("s59_dig0", {24'd0, dig[0]}, 32'd9);
        cycle(0, 0, 0);
        check("m1_dig4", {24'd0, dig[4]}, 32'd1);
        check("m1_dig3", {24'd0, dig[3]}, 32'd0);
        check("m1_dig2", {24'd0, dig[2]}, 32'd0);
        check("m1_dig1", {24'd0, dig[1]}, 32'd0);

        // Stop, clear, then the pause/resume sequence.
        cycle(1, 0, 0);
        cycle(0, 1, 0);
        check("clr_dig4", {24'd0, dig[4]}, 32'd0);
        cycle(1, 0, 0);                 // start from IDLE
        idle_cycles(5);
        cycle(1, 0, 0);                 // 6th edge after start: pause, p=2
        check("pause_run", {31'd0, running}, 32'd0);
        idle_cycles(20);
        check("pause_dig0", {24'd0, dig[0]}, 32'd1);
        cycle(1, 0, 0);                 // resume
        check("resume0_dig0", {24'd0, dig[0]}, 32'd1);
        cycle(0, 0, 0);
        check("resume1_dig0", {24'd0, dig[0]}, 32'd1);
        cycle(0, 0, 0);
        check("resume2_dig0", {24'd0, dig[0]}, 32'd2);

        // clear in RUN is ignored; clear+start_stop in STOP goes to IDLE.
        cycle(0, 1, 0);
        check("clr_in_run", {31'd0, running}, 32'd1);
        cycle(1, 0, 0);
        cycle(1, 1, 0);
        check("clrss_run",  {31'd0, running}, 32'd0);
        check("clrss_dig0", {24'd0, dig[0]}, 32'd0);
        check("clrss_ovf",  {31'd0, ovf},    32'd0);
        cycle(0, 0, 0);
        check("clrss_idle", {31'd0, running}, 32'd0);

        // Preload 99:59:59.99 while paused, resume and take the wrap.
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        force dut.cnt_q = 32'h9959_5999;
        m_total = LIMIT - 1;
        cycle(0, 0, 0);
        release dut.cnt_q;
        cycle(0, 0, 0);
        check("pre_dig7", {24'd0, dig[7]}, 32'd9);
        cycle(1, 0, 0);
        guard = 0;
        while (!m_ovf && guard < 2 * TD) begin
            cycle(0, 0, 0);
            guard++;
        end
        if (guard >= 2 * TD) check("timeout_wrap", 32'd0, 32'd1);
        check("wrap_ovf",  {31'd0, ovf},     32'd1);
        check("wrap_dig7", {24'd0, dig[7]},  32'd0);
        check("wrap_dig0", {24'd0, dig[0]},  32'd0);
        check("wrap_run",  {31'd0, running}, 32'd1);
        idle_cycles(TD);
        check("wrap_cont", {24'd0, dig[0]}, 32'd1);
        check("ovf_sticky", {31'd0, ovf}, 32'd1);

        // Asynchronous reset mid-count, between clock edges.
        #1;
        rst = 1;
        model_reset(0);
        #1;
        check_all();
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        @(posedge clk100MHZ);
        #1;
        check_all();
        rst = 0;
        cycle(0, 0, 0);

        // Lap: freeze at 00.05, run 20 more cycles, release.
        cycle(1, 0, 0);
        guard = 0;
        while (m_total != 5 && guard < 100) begin
            cycle(0, 0, 0);
            guard++;
        end
        if (guard >= 100) check("timeout_lap", 32'd0, 32'd1);
        cycle(0, 0, 1);
        idle_cycles(20);
`ifdef STOPWATCH_LAP_EN
        check("lap_active", {31'd0, lap_active}, 32'd1);
        check("lap_dig0",   {24'd0, dig[0]},    32'd5);
        check("lap_dig1",   {24'd0, dig[1]},    32'd0);
        cycle(0, 0, 1);
        check("unlap_dig0", {24'd0, dig[0]},    32'd0);
        check("unlap_dig1", {24'd0, dig[1]},    32'd1);
        check("unlap_act",  {31'd0, lap_active}, 32'd0);
`else
        check("nolap_active", {31'd0, lap_active}, 32'd0);
        check("nolap_dig1",   {24'd0, dig[1]},    32'd1);
        cycle(0, 0, 1);
`endif

        // Random pulses against the model.
        for (int i = 0; i < 3000; i++)
            cycle(($urandom % 20) == 0, ($urandom % 12) == 0, ($urandom % 10) == 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/stopwatch_bcd.md
# stopwatch_bcd

Eight-digit BCD stopwatch that produces the per-digit values and the display enable consumed by the eight-digit dynamic-scan display stage. It counts elapsed time as HH:MM:SS.cc from a prescaled 100 MHz clock under start/stop, clear and optional lap control. Its outputs connect directly to that stage's `power_led` and `dig0`..`dig7` inputs.

## Interface
Parameters:
- `TICK_DIV`, default 1000000: clock cycles per centisecond tick. 100 MHz / 1000000 = 100 Hz. Legal range is ≥2.

Ports:
- `clk100MHZ`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start_stop`  in  1  single-cycle pulse, already synchronized and debounced; toggles run/stop.
- `clear`  in  1  single-cycle pulse; zeroes the count when not running.
- `lap`  in  1  single-cycle pulse; toggles lap freeze. Active only with `STOPWATCH_LAP_EN`.
- `power_led`  out  1  display enable; 1 whenever not in reset.
- `dig0`..`dig7`  out  8 each  [3:0] BCD digit, [7:4] always 0.
- `running`  out  1  1 in state RUN.
- `lap_active`  out  1  1 while displayed digits are frozen.
- `ovf`  out  1  sticky wrap flag.

## Operation
- Digit map:
  - `dig0` = centisecond units, `dig1` = centisecond tens.
  - `dig2` = second units, `dig3` = second tens (0–5).
  - `dig4` = minute units, `dig5` = minute tens (0–5).
  - `dig6` = hour units, `dig7` = hour tens (0–9).
- Count range is 00:00:00.00 to 99:59:59.99.
- States: IDLE (count zero, stopped), RUN, STOP (paused, count held).
- Transitions:
  - IDLE + `start_stop` → RUN.
  - RUN + `start_stop` → STOP.
  - STOP + `start_stop` → RUN.
  - STOP + `clear` → IDLE.
  - IDLE + `clear` → no change.
  - RUN + `clear` → ignored.
- Simultaneous `clear` and `start_stop`:
  - In STOP or IDLE: `clear` wins and the next state is IDLE.
  - In RUN: `clear` is ignored and `start_stop` acts.
- Prescaler runs 0..TICK_DIV-1 and advances only in RUN.
  - A tick is asserted in the cycle where the prescaler equals TICK_DIV-1; the prescaler then wraps to 0.
  - In STOP the prescaler is held, so the partial centisecond is preserved.
  - Entering IDLE zeroes the prescaler.
- BCD chain on each tick:
  - Each digit increments; at its limit (9, or 5 for tens of seconds and tens of minutes) it wraps to 0 and carries to the next digit.
  - Full wrap from 99:59:59.99 → 00:00:00.00 sets `ovf`. Counting continues.
- `ovf` is cleared only by `rst` or by an honoured `clear`.
- Reset values: state IDLE, all digits 0, prescaler 0, `running`=0, `lap_active`=0, `ovf`=0.
- `power_led` is 0 while `rst` is asserted and 1 otherwise.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- `start_stop` sampled at edge N: `running` changes at edge N and is visible from cycle N+1.
- First tick after starting from IDLE: the live count first reads 00.01 after edge N+TICK_DIV.
- Subsequent ticks occur every TICK_DIV cycles of RUN time.
- Digit outputs update on the same edge that consumes the tick, with no additional pipeline delay.
- Resuming from STOP: the next tick occurs after the remaining TICK_DIV-1-p cycles, where p is the held prescaler value.
- A `rst` assertion at any time forces the reset values immediately, independent of the clock. This includes mid-count and mid-lap.

## Configuration
- `STOPWATCH_LAP_EN` defined:
  - A `lap` pulse when `lap_active`=0 in RUN copies the live count into a display register on that edge and sets `lap_active`=1.
  - While `lap_active`=1, `dig0`..`dig7` show the frozen value and the live count keeps advancing.
  - A `lap` pulse while `lap_active`=1, in any state, releases the freeze. The outputs show the live count from the next cycle.
  - An honoured `clear` also releases the freeze.
  - A `lap` pulse in IDLE or STOP with `lap_active`=0 is ignored.
- `STOPWATCH_LAP_EN` undefined:
  - `lap` is ignored.
  - `lap_active` is tied to 0.
  - The display register is not built; outputs always show the live count.

## Test plan
Use TICK_DIV=4 for all scenarios.
- Reset, then `start_stop` pulse, then 40 cycles → digits read 00:00:00.10, `running`=1, `power_led`=1.
- Run to 59.99 s, then one more tick → digits read 00:01:00.00, with the carry into `dig4` on the same edge.
- Start, run 6 cycles, `start_stop`, hold 20 cycles, `start_stop` → `dig0` is unchanged during STOP, and the next increment arrives 2 cycles after resume.
- In STOP, `clear` and `start_stop` in the same cycle → state IDLE, all digits 0, `ovf`=0.
- Preload near 99:59:59.99, then one tick → all digits 0, `ovf`=1, counting continues; assert `rst` mid-count → all outputs at reset values.
- With `STOPWATCH_LAP_EN`: `lap` at 00.05, run 20 more cycles → outputs hold 00.05 with `lap_active`=1; second `lap` → outputs read 00.10 the next cycle.
